hexkey: RTL and testbench

Scanner for a 4x4 hex keypad that turns two keystrokes into one byte for the SAP-1 input path. This is the input-side counterpart of the two-digit hex display. It drives the keypad rows, samples the column lines, debounces each press and release, and reports every accepted key as a strobed 4-bit code. Two keys are packed into an 8-bit byte, and that byte is held with a valid/ack handshake for the loader or CPU input port.

---
 rtl/sap1_io_pkg.sv | 33 +++
 rtl/hexkey_if.sv | 21 ++
 rtl/hexkey_tick_div.sv | 23 ++
 rtl/hexkey.sv | 160 ++++++++++++++++
 tb/tb_hexkey.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sap1_io_pkg.sv
// Shared definitions for the SAP-1 input path: keypad FSM states, line idle
// levels and small helpers for active-low one-hot patterns.
package sap1_io_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } key_state_e;

    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam logic [3:0] COL_IDLE  = 4'hF;

    // Position of the lowest 0 bit; only meaningful for a single-low pattern.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = i[1:0];
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    function automatic logic [3:0] rotate_row(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

endpackage

// File: rtl/hexkey_if.sv
// Keypad lines plus key/byte handshake of the hex keypad scanner.
interface hexkey_if;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_strobe;
    logic [3:0] key_code;
    logic [7:0] ibus;
    logic       in_valid;
    logic       in_ack;
    logic       overrun;

    modport master (
        input  col, in_ack,
        output row, key_strobe, key_code, ibus, in_valid, overrun
    );

    modport slave (
        output col, in_ack,
        input  row, key_strobe, key_code, ibus, in_valid, overrun
    );
endinterface

// File: rtl/hexkey_tick_div.sv
// Free-running divider: one-cycle tick whenever the count equals DIV,
// then wraps to zero, so ticks repeat every DIV+1 cycles.
module tick_div #(
    parameter int unsigned DIV = 4999
) (
    input  logic clk,
    input  logic CLR,
    output logic tick_o
);
    localparam int unsigned W = (DIV < 1) ? 1 : $clog2(DIV + 1);

    logic [W-1:0] cnt_q;

    assign tick_o = (cnt_q == W'(DIV));

    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR)         cnt_q <= '0;
        else if (tick_o) cnt_q <= '0;
        else             cnt_q <= cnt_q + W'(1);
    end
endmodule

// File: rtl/hexkey.sv
// 4x4 hex keypad scanner: row scan, tick-sampled debounce of press and
// release, and packing of two key codes into a byte with valid/ack.
module hexkey
    import sap1_io_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 4999,
    parameter int unsigned DEB_TICKS = 8
) (
    input logic      clk,
    input logic      CLR,
    hexkey_if.master bus
);
    localparam int unsigned DW = $clog2(DEB_TICKS + 1);

    logic          tick;
    logic [3:0]    col_meta_q, col_s_q;
    key_state_e    state_q, state_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    pat_q, pat_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [DW-1:0] deb_q, deb_d;
    logic          accept;
    logic [3:0]    code;

    logic          strobe_q;
    logic [3:0]    code_q, code_d;
    logic [7:0]    ibus_q, ibus_d;
    logic          valid_q, valid_d;
    logic          digit_q, digit_d;
    logic          ovr_q, ovr_d;

    tick_div #(.DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .CLR    (CLR),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            col_meta_q <= COL_IDLE;
            col_s_q    <= COL_IDLE;
        end else begin
            col_meta_q <= bus.col;
            col_s_q    <= col_meta_q;
        end
    end

    // Key code is {row index, column index}, i.e. 4*r + c.
    assign code = {low_index(row_q), cidx_q};

    // NOTE: every combinational output gets a default first so no path
    // leaves a variable unassigned and a latch is never inferred.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pat_d   = pat_q;
        cidx_d  = cidx_q;
        deb_d   = deb_q;
        accept  = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (is_single(col_s_q)) begin
                        pat_d   = col_s_q;
                        cidx_d  = low_index(col_s_q);
                        deb_d   = DW'(1);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        row_d = rotate_row(row_q);
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s_q == pat_q) begin
                        deb_d = deb_q + DW'(1);
                        if ((deb_q + DW'(1)) == DW'(DEB_TICKS)) begin
                            accept  = 1'b1;
                            state_d = ST_PRESSED;
                        end
                    end else begin
                        row_d   = rotate_row(row_q);
                        state_d = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (col_s_q == COL_IDLE) begin
                        deb_d   = DW'(1);
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (col_s_q == COL_IDLE) begin
                        deb_d = deb_q + DW'(1);
                        if ((deb_q + DW'(1)) == DW'(DEB_TICKS)) begin
                            row_d   = rotate_row(row_q);
                            state_d = ST_SCAN;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // An ack in the same cycle frees the byte before the new key is placed.
    always_comb begin
        code_d  = code_q;
        ibus_d  = ibus_q;
        valid_d = valid_q;
        digit_d = digit_q;
        ovr_d   = ovr_q;
        if (bus.in_ack && valid_q) valid_d = 1'b0;
        if (accept) begin
            code_d = code;
            if (!valid_d) begin
                ibus_d  = {ibus_q[3:0], code};
                digit_d = !digit_q;
                if (digit_q) valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q  <= ST_SCAN;
            row_q    <= ROW_RESET;
            pat_q    <= COL_IDLE;
            cidx_q   <= 2'd0;
            deb_q    <= '0;
            strobe_q <= 1'b0;
            code_q   <= 4'd0;
            ibus_q   <= 8'h00;
            valid_q  <= 1'b0;
            digit_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            pat_q    <= pat_d;
            cidx_q   <= cidx_d;
            deb_q    <= deb_d;
            strobe_q <= accept;
            code_q   <= code_d;
            ibus_q   <= ibus_d;
            valid_q  <= valid_d;
            digit_q  <= digit_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.row        = row_q;
    assign bus.key_strobe = strobe_q;
    assign bus.key_code   = code_q;
    assign bus.ibus       = ibus_q;
    assign bus.in_valid   = valid_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_hexkey.sv
// Bench for hexkey: cycle-exact directed scenarios with forced columns, then
// random keystrokes on a modelled keypad matrix against a byte-level model.
module tb_hexkey;
    import sap1_io_pkg::*;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    hexkey_if bus ();

    hexkey #(.SCAN_DIV(3), .DEB_TICKS(2)) dut (
        .clk (clk),
        .CLR (clr),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic        force_en;
    logic [3:0]  col_force;
    logic [15:0] keys;
    int          pos;

    // Passive keypad: a closed key ties its column low while its row is driven.
    function automatic logic [3:0] keypad(input logic [3:0] row, input logic [15:0] k);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                if (!row[r] && k[4*r+j]) c[j] = 1'b0;
        return c;
    endfunction

    assign bus.col = force_en ? col_force : keypad(bus.row, keys);

    typedef struct {
        logic [3:0] code;
        logic [7:0] ibus;
        logic       valid;
        logic       ovr;
    } strobe_t;

    strobe_t seen[$];
    int      n_strobe = 0;

    always @(negedge clk) begin
        if (bus.key_strobe === 1'b1) begin
            n_strobe++;
            seen.push_back('{bus.key_code, bus.ibus, bus.in_valid, bus.overrun});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Advance to just after the negedge following clock edge e since reset release.
    task automatic goto(input int e);
        while (pos < e) begin
            step();
            pos++;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        pos = 0;
        #1;
    endtask

    int n0;
    logic [7:0] ref_ibus;
    logic       ref_valid, ref_ovr;
    int         ref_digits;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        clr = 1'b1;
        force_en = 1'b1;
        col_force = 4'hF;
        keys = '0;
        bus.in_ack = 1'b0;

        // Reset mid-scan and row rotation once per 4 cycles.
        reset_dut();
        goto(6);
        clr = 1'b1;
        #1;
        check("rst_row", bus.row, 4'b1110);
        check("rst_ibus", bus.ibus, 8'h00);
        check("rst_valid", bus.in_valid, 1'b0);
        check("rst_ovr", bus.overrun, 1'b0);
        check("rst_strobe", bus.key_strobe, 1'b0);
        check("rst_code", bus.key_code, 4'h0);
        reset_dut();
        goto(3);  check("rot_e3", bus.row, 4'b1110);
        goto(4);  check("rot_e4", bus.row, 4'b1101);
        goto(7);  check("rot_e7", bus.row, 4'b1101);
        goto(8);  check("rot_e8", bus.row, 4'b1011);
        goto(12); check("rot_e12", bus.row, 4'b0111);
        goto(16); check("rot_e16", bus.row, 4'b1110);

        // Multi-key pattern is ignored.
        n0 = n_strobe;
        col_force = 4'b1100;
        goto(20); check("multi_row20", bus.row, 4'b1101);
        goto(24); check("multi_row24", bus.row, 4'b1011);
        goto(40); check("multi_nostrobe", n_strobe, n0);

        // Byte assembly, ack coincident with accept, overrun.
        col_force = 4'b1110;
        reset_dut();
        n0 = n_strobe;
        goto(7);  check("k0_early", n_strobe, n0);
        goto(8);
        check("k0_strobe", n_strobe, n0 + 1);
        check("k0_code", bus.key_code, 4'h0);
        check("k0_valid", bus.in_valid, 1'b0);
        col_force = 4'hF;
        goto(16);
        check("k0_rel_row", bus.row, 4'b1101);
        check("k0_once", n_strobe, n0 + 1);
        col_force = 4'b1101;
        goto(24);
        check("k5_code", bus.key_code, 4'h5);
        check("k5_ibus", bus.ibus, 8'h05);
        check("k5_valid", bus.in_valid, 1'b1);
        col_force = 4'hF;
        goto(32); check("k5_rel_row", bus.row, 4'b1011);
        col_force = 4'b1011;
        goto(39); bus.in_ack = 1'b1;
        goto(40); bus.in_ack = 1'b0;
        check("sim_strobe", n_strobe, n0 + 3);
        check("sim_code", bus.key_code, 4'hA);
        check("sim_valid", bus.in_valid, 1'b0);
        check("sim_low", bus.ibus[3:0], 4'hA);
        check("sim_ovr", bus.overrun, 1'b0);
        col_force = 4'hF;
        goto(48);
        col_force = 4'b0111;
        goto(56);
        check("kF_ibus", bus.ibus, 8'hAF);
        check("kF_valid", bus.in_valid, 1'b1);
        col_force = 4'hF;
        goto(64);
        col_force = 4'b0111;
        goto(72);
        check("ovr_strobe", n_strobe, n0 + 5);
        check("ovr_code", bus.key_code, 4'h3);
        check("ovr_ibus", bus.ibus, 8'hAF);
        check("ovr_flag", bus.overrun, 1'b1);
        col_force = 4'hF;
        goto(73); bus.in_ack = 1'b1;
        goto(74); bus.in_ack = 1'b0;
        check("ack_valid", bus.in_valid, 1'b0);
        check("ack_ibus", bus.ibus, 8'hAF);
        check("ack_ovr_sticky", bus.overrun, 1'b1);

        // Press bounce: toggling each tick during debounce never accepts.
        col_force = 4'b1110;
        reset_dut();
        n0 = n_strobe;
        goto(4);  col_force = 4'hF;
        goto(8);  check("bnc_row8", bus.row, 4'b1101);
        col_force = 4'b1110;
        goto(12); col_force = 4'hF;
        goto(16); check("bnc_row16", bus.row, 4'b1011);
        goto(20); check("bnc_row20", bus.row, 4'b0111);
        check("bnc_nostrobe", n_strobe, n0);

        // Short release bounce gives no second strobe.
        col_force = 4'b1110;
        reset_dut();
        n0 = n_strobe;
        goto(8);  col_force = 4'hF;
        goto(12); col_force = 4'b1110;
        goto(24); col_force = 4'hF;
        goto(32);
        check("rbnc_row", bus.row, 4'b1101);
        check("rbnc_once", n_strobe, n0 + 1);

        // Reset while a key is held: it must debounce again.
        col_force = 4'b1110;
        reset_dut();
        goto(10);
        reset_dut();
        n0 = n_strobe;
        goto(7);  check("clr_held_early", n_strobe, n0);
        goto(8);  check("clr_held_redet", n_strobe, n0 + 1);

        // Random keystrokes on the keypad matrix against the byte model.
        col_force = 4'hF;
        force_en = 1'b0;
        keys = '0;
        reset_dut();
        ref_ibus = 8'h00;
        ref_valid = 1'b0;
        ref_ovr = 1'b0;
        ref_digits = 0;
        for (int it = 0; it < 24; it++) begin
            logic [3:0] k;
            if ($urandom_range(0, 1) == 1) begin
                bus.in_ack = 1'b1;
                step();
                bus.in_ack = 1'b0;
                if (ref_valid) ref_valid = 1'b0;
            end
            k = 4'($urandom_range(0, 15));
            seen.delete();
            n0 = n_strobe;
            keys = 16'(1) << k;
            repeat ($urandom_range(60, 90)) step();
            keys = '0;
            repeat ($urandom_range(40, 60)) step();
            if (!ref_valid) begin
                ref_ibus = {ref_ibus[3:0], k};
                ref_digits = ref_digits + 1;
                if (ref_digits == 2) begin
                    ref_valid = 1'b1;
                    ref_digits = 0;
                end
            end else begin
                ref_ovr = 1'b1;
            end
            check("rnd_count", n_strobe - n0, 1);
            if (seen.size() > 0) begin
                check("rnd_code", seen[0].code, k);
                check("rnd_ibus", seen[0].ibus, ref_ibus);
                check("rnd_valid", seen[0].valid, ref_valid);
                check("rnd_ovr", seen[0].ovr, ref_ovr);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
